fetch_unit: RTL and testbench

//  Program-counter plus instruction-register stage feeding the controller's Opcode input.

---
 rtl/fetch_unit.sv | 142 ++++++++++++++
 tb/tb_fetch_unit.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// PC + instruction-register stage: holds the PC, applies IncPC/LoadPC/SelPC and fetches
// one opcode per LoadIR over a req/ack handshake. Optional fetch timeout: FETCH_TIMEOUT_EN.
module fetch_unit #(
  parameter int ADDR_W = 8
`ifdef FETCH_TIMEOUT_EN
  , parameter int TIMEOUT = 15
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_ir,
  input  logic              inc_pc,
  input  logic              load_pc,
  input  logic              sel_pc,
  input  logic [ADDR_W-1:0] jump_reg,
  input  logic [3:0]        jump_imm,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack,
  output logic [7:0]        opcode,
  output logic              ir_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              seq_err,
  output logic              fault
);

  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_e;

  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_HALT = 8'hF0;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        opcode_q, opcode_d;
  logic              ir_valid_q, ir_valid_d;
  logic              seq_err_q, seq_err_d;
  logic              pc_strobe;
  logic              timed_out;

  assign pc_strobe = load_pc | inc_pc;

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fault_q, fault_d;

  // Counts completed REQ cycles; expiry on the TIMEOUT-th one, ack takes precedence.
  assign timed_out = (state_q == REQ) && !mem_ack && (cnt_q == CNT_W'(TIMEOUT - 1));
  assign cnt_d     = (state_q == REQ) ? cnt_q + CNT_W'(1) : '0;
  assign fault_d   = fault_q | timed_out;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end

  assign fault = fault_q;
`else
  assign timed_out = 1'b0;
  assign fault     = 1'b0;
`endif

  // State register (plus datapath registers)
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      pc_q       <= '0;
      mem_addr_q <= '0;
      opcode_q   <= OP_NOP;
      ir_valid_q <= 1'b0;
      seq_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      mem_addr_q <= mem_addr_d;
      opcode_q   <= opcode_d;
      ir_valid_q <= ir_valid_d;
      seq_err_q  <= seq_err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load_ir) state_d = REQ;
      REQ:     if (mem_ack || timed_out) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values
  always_comb begin
    pc_d       = pc_q;
    mem_addr_d = mem_addr_q;
    opcode_d   = opcode_q;
    ir_valid_d = 1'b0;
    seq_err_d  = seq_err_q;

    if (state_q == IDLE) begin
      if (load_ir) begin
        // Fetch takes the pre-update PC; a coincident PC strobe is lost.
        mem_addr_d = pc_q;
        if (pc_strobe) seq_err_d = 1'b1;
      end else if (load_pc) begin
        pc_d = sel_pc ? {{(ADDR_W-4){1'b0}}, jump_imm} : jump_reg;
      end else if (inc_pc) begin
        pc_d = pc_q + ADDR_W'(1);
      end
    end else begin
      if (pc_strobe) seq_err_d = 1'b1;
      if (mem_ack) begin
        opcode_d   = mem_rdata;
        ir_valid_d = 1'b1;
      end else if (timed_out) begin
        opcode_d   = OP_HALT;
        ir_valid_d = 1'b1;
      end
    end
  end

  // Outputs
  always_comb begin
    mem_req  = (state_q == REQ);
    busy     = (state_q == REQ);
    mem_addr = mem_addr_q;
    opcode   = opcode_q;
    ir_valid = ir_valid_q;
    pc       = pc_q;
    seq_err  = seq_err_q;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: PC vector table, hand-written fetch sequences,
// and a randomized run against a behavioural model.
module tb_fetch_unit;

  logic       clk = 1'b0;
  logic       reset, load_ir, inc_pc, load_pc, sel_pc, mem_ack;
  logic [7:0] jump_reg, mem_rdata;
  logic [3:0] jump_imm;
  logic       mem_req, ir_valid, busy, seq_err, fault;
  logic [7:0] mem_addr, opcode, pc;

  int tests = 0;
  int fails = 0;

  logic [7:0] imem [256];

  fetch_unit dut (
    .clk(clk), .reset(reset), .load_ir(load_ir), .inc_pc(inc_pc), .load_pc(load_pc),
    .sel_pc(sel_pc), .jump_reg(jump_reg), .jump_imm(jump_imm), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .opcode(opcode),
    .ir_valid(ir_valid), .pc(pc), .busy(busy), .seq_err(seq_err), .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ld;
    logic       inc;
    logic       sel;
    logic [7:0] jreg;
    logic [3:0] jimm;
    logic [7:0] exp_pc;
  } pc_vec_t;

  pc_vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    load_ir = 0; inc_pc = 0; load_pc = 0; sel_pc = 0;
    jump_reg = 8'h00; jump_imm = 4'h0; mem_ack = 0; mem_rdata = 8'h00;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    step();
    reset = 0;
  endtask

  // One fetch at exp_addr; ack after 'delay' idle REQ cycles, optional inc_pc while waiting.
  task automatic fetch(input logic [7:0] exp_addr, input int delay, input logic [7:0] data,
                       input logic poke_inc);
    load_ir = 1;
    step();
    load_ir = 0;
    check("ir_valid_low_after_load", ir_valid, 0);
    check("mem_req_start", mem_req, 1);
    check("busy_start", busy, 1);
    check("mem_addr_start", mem_addr, exp_addr);
    for (int d = 0; d < delay; d++) begin
      inc_pc = poke_inc;
      step();
      inc_pc = 0;
      check("mem_req_hold", mem_req, 1);
      check("mem_addr_hold", mem_addr, exp_addr);
      check("ir_valid_wait", ir_valid, 0);
    end
    mem_ack = 1; mem_rdata = data;
    step();
    mem_ack = 0;
    check("ir_valid_pulse", ir_valid, 1);
    check("opcode_latched", opcode, data);
    check("mem_req_drop", mem_req, 0);
    check("busy_drop", busy, 0);
  endtask

  // Behavioural model state for the random phase
  logic [7:0] m_pc, m_op, m_addr;
  logic       m_err, m_fetching, m_valid;
  int         m_wait;

  initial begin
    vecs[0] = '{1, 0, 0, 8'hFF, 4'h0, 8'hFF};
    vecs[1] = '{0, 1, 0, 8'h00, 4'h0, 8'h00};
    vecs[2] = '{1, 0, 1, 8'h00, 4'h9, 8'h09};
    vecs[3] = '{1, 0, 0, 8'h3C, 4'h0, 8'h3C};
    vecs[4] = '{1, 1, 0, 8'h20, 4'h0, 8'h20};
    vecs[5] = '{0, 1, 0, 8'h00, 4'h0, 8'h21};
    vecs[6] = '{0, 0, 0, 8'h77, 4'h3, 8'h21};
    vecs[7] = '{1, 0, 1, 8'hAA, 4'hF, 8'h0F};
    vecs[8] = '{1, 1, 0, 8'h00, 4'h0, 8'h00};
    for (int i = 0; i < 256; i++) imem[i] = 8'($urandom);

    reset = 1;
    idle_inputs();
    step(); step();
    reset = 0;
    check("rst_pc", pc, 0);
    check("rst_opcode", opcode, 8'h00);
    check("rst_ir_valid", ir_valid, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_busy", busy, 0);
    check("rst_seq_err", seq_err, 0);
    check("rst_fault", fault, 0);

    // Fetch with immediate ack, then a back-to-back fetch
    fetch(8'h00, 0, 8'h4A, 0);
    check("pc_unchanged_by_fetch", pc, 0);
    fetch(8'h00, 1, 8'h5B, 0);
    step();
    check("ir_valid_one_cycle", ir_valid, 0);

    // PC vector table
    for (int i = 0; i < 9; i++) begin
      load_pc = vecs[i].ld; inc_pc = vecs[i].inc; sel_pc = vecs[i].sel;
      jump_reg = vecs[i].jreg; jump_imm = vecs[i].jimm;
      step();
      check($sformatf("pc_vec%0d", i), pc, vecs[i].exp_pc);
    end
    idle_inputs();
    check("seq_err_clean_after_table", seq_err, 0);

    // Delayed ack with inc_pc during the wait
    fetch(8'h00, 5, 8'hC3, 1);
    check("pc_held_in_req", pc, 0);
    check("seq_err_in_req", seq_err, 1);

    // load_ir with inc_pc in IDLE: fetch uses old PC, update dropped
    do_reset();
    load_pc = 1; jump_reg = 8'h40;
    step();
    load_pc = 0;
    inc_pc = 1;
    fetch(8'h40, 0, 8'h11, 0);
    check("pc_not_incremented", pc, 8'h40);
    check("seq_err_coincident", seq_err, 1);

    // Reset mid-REQ, stale ack two cycles later
    do_reset();
    load_ir = 1;
    step();
    load_ir = 0;
    reset = 1;
    step();
    reset = 0;
    check("midreq_mem_req", mem_req, 0);
    step();
    mem_ack = 1; mem_rdata = 8'h77;
    step();
    mem_ack = 0;
    check("stale_ack_ir_valid", ir_valid, 0);
    check("stale_ack_opcode", opcode, 8'h00);
    check("stale_ack_busy", busy, 0);

    // Missing ack
    do_reset();
    load_ir = 1;
    step();
    load_ir = 0;
`ifdef FETCH_TIMEOUT_EN
    begin
      int n;
      n = 0;
      while (!ir_valid && n < 40) begin
        step();
        n++;
      end
      check("timeout_cycles", n, 15);
      check("timeout_opcode", opcode, 8'hF0);
      check("timeout_fault", fault, 1);
      check("timeout_mem_req", mem_req, 0);
    end
`else
    for (int n = 0; n < 20; n++) step();
    check("no_timeout_busy", busy, 1);
    check("no_timeout_fault", fault, 0);
`endif

    // Randomized run against the model
    do_reset();
    m_pc = 0; m_op = 0; m_addr = 0; m_err = 0; m_fetching = 0; m_wait = 0;
    for (int c = 0; c < 400; c++) begin
      reset    = ($urandom_range(0, 39) == 0);
      load_ir  = ($urandom_range(0, 3) == 0);
      inc_pc   = ($urandom_range(0, 2) == 0);
      load_pc  = ($urandom_range(0, 4) == 0);
      sel_pc   = 1'($urandom);
      jump_reg = 8'($urandom);
      jump_imm = 4'($urandom);
      mem_ack  = m_fetching ? ($urandom_range(0, 2) == 0 || m_wait >= 4)
                            : ($urandom_range(0, 7) == 0);
      mem_rdata = m_fetching ? imem[m_addr] : 8'($urandom);
      m_valid = 0;
      if (reset) begin
        m_pc = 0; m_op = 0; m_addr = 0; m_err = 0; m_fetching = 0;
      end else if (!m_fetching) begin
        if (load_ir) begin
          m_fetching = 1; m_addr = m_pc; m_wait = 0;
          if (load_pc || inc_pc) m_err = 1;
        end else if (load_pc) m_pc = sel_pc ? {4'h0, jump_imm} : jump_reg;
        else if (inc_pc) m_pc = m_pc + 8'd1;
      end else begin
        if (load_pc || inc_pc) m_err = 1;
        if (mem_ack) begin
          m_op = mem_rdata; m_valid = 1; m_fetching = 0;
        end else m_wait++;
      end
      step();
      check("rand_pc", pc, m_pc);
      check("rand_opcode", opcode, m_op);
      check("rand_ir_valid", ir_valid, m_valid);
      check("rand_busy", busy, m_fetching);
      check("rand_mem_req", mem_req, m_fetching);
      check("rand_seq_err", seq_err, m_err);
      if (m_fetching) check("rand_mem_addr", mem_addr, m_addr);
    end
    idle_inputs();
    reset = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
